// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

    localparam int IC_INDEX_BITS_DEF  = 6;
    localparam int IC_OFFSET_LOG_DEF  = 2;
    localparam int IC_ADDR_WIDTH_DEF  = 32;
    localparam int IC_INSTR_LEN       = 32;

    // Cache controller states; exposed on the top's state_dbg port.
    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_REFILL  = 2'd1,
        IC_RESPOND = 2'd2
    } ic_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
//
// Handshakes:
//   fetch side  - fetch raises icache_enable with pc_to_fetch and holds both
//                 stable until it samples icache_success=1 (a one-cycle pulse
//                 carrying instr_fetched); it then drops or changes the request.
//   memory side - the cache holds mc_req=1 with mc_addr for the current beat;
//                 the controller answers with mc_valid=1 and mc_word for that
//                 address, and the cache advances mc_addr on every accepted beat.
interface icache_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  icache_enable;
    logic [ADDR_WIDTH-1:0] pc_to_fetch;
    logic [31:0]           instr_fetched;
    logic                  icache_success;
    logic                  mc_req;
    logic [ADDR_WIDTH-1:0] mc_addr;
    logic                  mc_valid;
    logic [31:0]           mc_word;

    // Cache view.
    modport slave (
        input  icache_enable, pc_to_fetch, mc_valid, mc_word,
        output instr_fetched, icache_success, mc_req, mc_addr
    );

    // Environment view (fetch stage plus memory controller).
    modport master (
        output icache_enable, pc_to_fetch, mc_valid, mc_word,
        input  instr_fetched, icache_success, mc_req, mc_addr
    );
endinterface

// File: rtl/icache_array.sv
// Tag/valid/data storage: one combinational read port, one word write port
// and one tag/valid write port. Only the valid bits are reset.
module icache_array #(
    parameter int INDEX_BITS       = 6,
    parameter int OFFSET_WORDS_LOG = 2,
    parameter int TAG_BITS         = 22
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INDEX_BITS-1:0]       rd_index,
    input  logic [OFFSET_WORDS_LOG-1:0] rd_offset,
    output logic                        rd_valid,
    output logic [TAG_BITS-1:0]         rd_tag,
    output logic [31:0]                 rd_data,
    input  logic                        wr_word_en,
    input  logic [INDEX_BITS-1:0]       wr_index,
    input  logic [OFFSET_WORDS_LOG-1:0] wr_offset,
    input  logic [31:0]                 wr_data,
    input  logic                        wr_tag_en,
    input  logic [TAG_BITS-1:0]         wr_tag
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_WORDS_LOG;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES][WORDS];

    // Valid bits: cleared by reset, set when a line's last beat installs its tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_tag_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_tag_en) begin
            tag_q[wr_index] <= wr_tag;
        end
        if (wr_word_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache between fetch and the memory
// controller. Misses refill the whole line in order (offset 0..N-1) and then
// answer the pending request; a ROB flush cancels the in-flight answer but
// never abandons a refill.
// Optional build macro ICACHE_STATS_EN adds hit_count / miss_count outputs.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS       = IC_INDEX_BITS_DEF,
    parameter int OFFSET_WORDS_LOG = IC_OFFSET_LOG_DEF,
    parameter int ADDR_WIDTH       = IC_ADDR_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    icache_if.slave     bus,
    output ic_state_e   state_dbg
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_LSB  = OFFSET_WORDS_LOG + 2;
    localparam int TAG_LSB  = IDX_LSB + INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - TAG_LSB;

    ic_state_e                   state, state_nx;
    logic [ADDR_WIDTH-1:2]       req_pc;
    logic [ADDR_WIDTH-1:2]       rd_pc;
    logic [OFFSET_WORDS_LOG-1:0] beat;
    logic                        drop;
    logic                        success_q;
    logic [31:0]                 instr_q;
    logic                        mc_req_q;
    logic [ADDR_WIDTH-1:0]       mc_addr_q;

    logic                        rd_valid;
    logic [TAG_BITS-1:0]         rd_tag;
    logic [31:0]                 rd_data;
    logic                        accept, hit, beat_fire, last_beat;

    // IDLE looks up the live PC; REFILL/RESPOND look up the latched request.
    assign rd_pc = (state == IC_IDLE) ? bus.pc_to_fetch[ADDR_WIDTH-1:2] : req_pc;

    // A request held across its own success pulse must not be re-accepted.
    assign accept    = rdy && (state == IC_IDLE) && bus.icache_enable && !flush && !success_q;
    assign hit       = rd_valid && (rd_tag == bus.pc_to_fetch[ADDR_WIDTH-1:TAG_LSB]);
    assign beat_fire = rdy && (state == IC_REFILL) && bus.mc_valid;
    assign last_beat = &beat;

    icache_array #(
        .INDEX_BITS       (INDEX_BITS),
        .OFFSET_WORDS_LOG (OFFSET_WORDS_LOG),
        .TAG_BITS         (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (rd_pc[TAG_LSB-1:IDX_LSB]),
        .rd_offset  (rd_pc[IDX_LSB-1:2]),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_word_en (beat_fire),
        .wr_index   (req_pc[TAG_LSB-1:IDX_LSB]),
        .wr_offset  (beat),
        .wr_data    (bus.mc_word),
        .wr_tag_en  (beat_fire && last_beat),
        .wr_tag     (req_pc[ADDR_WIDTH-1:TAG_LSB])
    );

    // State register; rdy=0 freezes the controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IC_IDLE;
        end else if (rdy) begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IC_IDLE:    if (accept && !hit) state_nx = IC_REFILL;
            IC_REFILL:  if (beat_fire && last_beat) state_nx = IC_RESPOND;
            IC_RESPOND: state_nx = IC_IDLE;
            default:    state_nx = IC_IDLE;
        endcase
    end

    // Datapath: success pulse, returned word, refill beat tracking, drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            success_q <= 1'b0;
            instr_q   <= '0;
            mc_req_q  <= 1'b0;
            mc_addr_q <= '0;
            beat      <= '0;
            drop      <= 1'b0;
            req_pc    <= '0;
        end else if (rdy) begin
            success_q <= 1'b0;
            unique case (state)
                IC_IDLE: begin
                    if (accept && hit) begin
                        success_q <= 1'b1;
                        instr_q   <= rd_data;
                    end else if (accept) begin
                        req_pc    <= bus.pc_to_fetch[ADDR_WIDTH-1:2];
                        beat      <= '0;
                        mc_req_q  <= 1'b1;
                        mc_addr_q <= {bus.pc_to_fetch[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
                    end
                end
                IC_REFILL: begin
                    if (flush) drop <= 1'b1;
                    if (beat_fire) begin
                        beat      <= beat + 1'b1;
                        mc_addr_q <= mc_addr_q + ADDR_WIDTH'(4);
                        if (last_beat) mc_req_q <= 1'b0;
                    end
                end
                IC_RESPOND: begin
                    // A flush in this very cycle cancels the answer as well.
                    if (!(drop || flush)) begin
                        success_q <= 1'b1;
                        instr_q   <= rd_data;
                    end
                    drop <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    // Accepted-request counters; flushed requests still count once accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

    assign bus.icache_success = success_q;
    assign bus.instr_fetched  = instr_q;
    assign bus.mc_req         = mc_req_q;
    assign bus.mc_addr        = mc_addr_q;
    assign state_dbg          = state;

endmodule

// File: tb/tb_icache.sv
// Directed scoreboard bench for icache: stimulus pushes the expected
// instruction word, a negedge monitor pops it whenever icache_success pulses.
module tb_icache;
    import icache_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      rdy;
    logic      flush;
    ic_state_e state_dbg;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_if ifc ();

    icache u_dut (
        .clk        (clk),
        .rst        (rst_n),
        .rdy        (rdy),
        .flush      (flush),
        .bus        (ifc.slave),
        .state_dbg  (state_dbg)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];
    logic        prev_success = 1'b0;

    always @(posedge clk) cyc++;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic fail(input string name, input string why);
        n_checks++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Memory contents: line 0x10 holds 0xA0..0xA3, elsewhere addr ^ 0x5A5A0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [1:0] w;
        w = a[3:2];
        if (a < 32'h20) return 32'hA0 + {30'd0, w};
        return a ^ 32'h5A5A_0000;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && ifc.icache_success) begin
            if (prev_success) fail("success_back_to_back", "pulse in two consecutive cycles");
            if (exp_q.size() == 0) begin
                fail("unexpected_success", $sformatf("pulse with 0x%08h, none expected", ifc.instr_fetched));
            end else begin
                check("instr_fetched", ifc.instr_fetched, exp_q.pop_front());
            end
        end
        prev_success = rst_n && ifc.icache_success;
    end

    // ---------------- driver tasks ----------------
    // Serve one line refill beat by beat, optionally stalling rdy before beat
    // stall_at or raising flush (and dropping the fetch request) with beat flush_at.
    task automatic serve_line(input logic [31:0] base, input int stall_at, input int flush_at);
        int n = 0;
        while (!ifc.mc_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.mc_req) begin
            fail("mc_req_timeout", "mc_req never rose");
            return;
        end
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            if (b == stall_at) begin
                ifc.mc_valid = 1'b0;
                rdy = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check("stall_mc_req", {31'd0, ifc.mc_req}, 32'd1);
                    check("stall_mc_addr", ifc.mc_addr, base + 32'(4 * b));
                end
                rdy = 1'b1;
            end
            check("mc_addr_beat", ifc.mc_addr, base + 32'(4 * b));
            ifc.mc_valid = 1'b1;
            ifc.mc_word  = mem_word(base + 32'(4 * b));
            if (b == flush_at) begin
                flush = 1'b1;
                ifc.icache_enable = 1'b0;
            end else begin
                flush = 1'b0;
            end
        end
        @(negedge clk);
        ifc.mc_valid = 1'b0;
        flush = 1'b0;
    endtask

    // Issue one fetch and wait for its answer; checks latency.
    task automatic request(input logic [31:0] pc, input logic [31:0] exp, input bit miss,
                           input int stall_at, input int exp_lat);
        int start;
        int n;
        @(negedge clk);
        ifc.pc_to_fetch   = pc;
        ifc.icache_enable = 1'b1;
        exp_q.push_back(exp);
        start = cyc;
        if (miss) serve_line({pc[31:4], 4'h0}, stall_at, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.icache_success && n < 30);
        if (!ifc.icache_success) begin
            fail("success_timeout", $sformatf("no icache_success for pc 0x%08h", pc));
        end else begin
            check("latency", 32'(cyc - start), 32'(exp_lat));
            if (!miss) check("hit_no_mc_req", {31'd0, ifc.mc_req}, 32'd0);
        end
        ifc.icache_enable = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        rdy   = 1'b1;
        flush = 1'b0;
        ifc.icache_enable = 1'b0;
        ifc.pc_to_fetch   = '0;
        ifc.mc_valid      = 1'b0;
        ifc.mc_word       = '0;
        repeat (3) @(negedge clk);
        check("rst_success", {31'd0, ifc.icache_success}, 32'd0);
        check("rst_instr",   ifc.instr_fetched, 32'd0);
        check("rst_mc_req",  {31'd0, ifc.mc_req}, 32'd0);
        check("rst_mc_addr", ifc.mc_addr, 32'd0);
        check("rst_state",   {30'd0, state_dbg}, {30'd0, IC_IDLE});
        rst_n = 1'b1;

        // Cold miss, then hit in the same line.
        request(32'h0000_0010, 32'h0000_00A0, 1'b1, -1, 6);
`ifdef ICACHE_STATS_EN
        check("miss_count_cold", miss_count, 32'd1);
`endif
        request(32'h0000_001C, 32'h0000_00A3, 1'b0, -1, 1);
`ifdef ICACHE_STATS_EN
        check("hit_count_first", hit_count, 32'd1);
`endif

        // Conflict eviction: same index, different tag, then the original misses.
        request(32'h0000_0410, 32'h5A5A_0410, 1'b1, -1, 6);
        request(32'h0000_0010, 32'h0000_00A0, 1'b1, -1, 6);

        // Flush mid-refill: all beats complete, no pulse, line installed.
        @(negedge clk);
        ifc.pc_to_fetch   = 32'h0000_2000;
        ifc.icache_enable = 1'b1;
        serve_line(32'h0000_2000, -1, 2);
        repeat (4) @(negedge clk);
        check("flush_back_idle", {30'd0, state_dbg}, {30'd0, IC_IDLE});
        request(32'h0000_2004, 32'h5A5A_2004, 1'b0, -1, 1);

        // rdy stall before beat 1, then a hit in the filled line.
        request(32'h0000_3008, 32'h5A5A_3008, 1'b1, 1, 9);
        request(32'h0000_300C, 32'h5A5A_300C, 1'b0, -1, 1);

        // Flush in IDLE: the hitting request is ignored.
        @(negedge clk);
        ifc.pc_to_fetch   = 32'h0000_300C;
        ifc.icache_enable = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("idle_flush_no_pulse", {31'd0, ifc.icache_success}, 32'd0);
        check("idle_flush_no_req",   {31'd0, ifc.mc_req}, 32'd0);
        ifc.icache_enable = 1'b0;
        flush = 1'b0;
`ifdef ICACHE_STATS_EN
        check("hit_count_total",  hit_count,  32'd3);
        check("miss_count_total", miss_count, 32'd5);
`endif

        // Asynchronous reset in the middle of a refill.
        @(negedge clk);
        ifc.pc_to_fetch   = 32'h0000_4000;
        ifc.icache_enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.mc_req && n < 20);
        ifc.mc_valid = 1'b1;
        ifc.mc_word  = mem_word(32'h0000_4000);
        @(posedge clk);
        #2;
        check("pre_reset_mc_addr", ifc.mc_addr, 32'h0000_4004);
        rst_n = 1'b0;
        #1;
        check("async_rst_mc_req",  {31'd0, ifc.mc_req}, 32'd0);
        check("async_rst_mc_addr", ifc.mc_addr, 32'd0);
        check("async_rst_state",   {30'd0, state_dbg}, {30'd0, IC_IDLE});
        ifc.mc_valid      = 1'b0;
        ifc.icache_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef ICACHE_STATS_EN
        check("stats_after_reset", hit_count | miss_count, 32'd0);
`endif
        // Valid bits were cleared: the line at 0x10 must refill.
        request(32'h0000_0010, 32'h0000_00A0, 1'b1, -1, 6);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
